tiro_multi: RTL and testbench
=============================

# tiro_multi

Parametrised shot manager for AstroGenius: owns a table of N_TIROS projectile slots (x, y, direction, valid), spawns shots from the ship on request, advances every live shot one cell per game tick, and retires shots that leave the field or hit the asteroid under test. It succeeds the fixed 16-slot, 4-bit shot datapath. It adds its own sequencing FSM, a spawn handshake, free-slot allocation, hit reporting and an optional fire cooldown. It sits between the game control FSM and the display scanner.

## Interface

- N_TIROS, 16, number of shot slots (≥2)
- COOR_W, 4, coordinate width in bits
- X_MAX, 14, largest legal x; x range is 0..X_MAX
- Y_MAX, 14, largest legal y; y range is 0..Y_MAX
- COOLDOWN, 3, ticks after a spawn during which fire is refused (only with TIRO_COOLDOWN_EN)

- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- tick  in  1  one-cycle pulse; start one movement sweep
- fire  in  1  one-cycle pulse; request a new shot
- nave_x / nave_y  in  COOR_W  ship position; sampled with fire
- nave_dir  in  2  shot direction: 00 up (y−1), 01 right (x+1), 10 down (y+1), 11 left (x−1)
- aste_valid  in  1  aste_x/aste_y are meaningful; held stable during a sweep
- aste_x / aste_y  in  COOR_W  asteroid position
- rd_addr  in  clog2(N_TIROS)  display read index
- rd_valid / rd_x / rd_y  out  1 / COOR_W / COOR_W  combinational read of slot rd_addr
- fire_ack  out  1  pulse; shot placed
- fire_drop  out  1  pulse; request refused
- hit  out  1  pulse; a shot reached the asteroid
- hit_idx  out  clog2(N_TIROS)  slot index valid with hit
- busy  out  1  sweep in progress
- done  out  1  pulse at the end of a sweep
- live_count  out  clog2(N_TIROS+1)  number of valid slots

## Operation

- **States:** IDLE, MOVE, DONE.
- **IDLE + tick:** go to MOVE with idx = 0. A tick always wins over a simultaneous fire. That fire is latched as pending.
- **IDLE + fire (or pending set):** allocate the lowest-index free slot, loaded with {nave_x, nave_y, nave_dir, valid=1}. The shot is not moved in the spawn cycle.
  - No free slot, or cooldown active: issue fire_drop and clear pending.
- **MOVE:** one slot per cycle, slot idx. Invalid slots are skipped and still take their cycle.
  - Compute the next position in COOR_W+1 bits.
  - If the next position is below 0 or above X_MAX/Y_MAX, clear valid (border despawn, no pulse).
  - Else if aste_valid and the next position equals {aste_x, aste_y}, clear valid and pulse hit with hit_idx = idx.
  - Otherwise write the next position back.
  - After idx = N_TIROS−1, go to DONE.
- **DONE:** pulse done and decrement cooldown if it is nonzero. Then go to IDLE, where a pending fire is serviced.
- **fire during MOVE/DONE:** set pending (one deep). A fire arriving while pending is already set issues an immediate fire_drop. The pending request keeps the nave_* values sampled when it arrived.
- **tick during MOVE/DONE:** ignored; the sweep is not restarted.
- **live_count:** tracks spawns and retirements in the same cycle they occur.
- **Reset values:** all slots invalid; live_count 0; pending 0; cooldown 0; state IDLE; all pulses, busy and hit_idx 0.

## Timing

- Spawn latency:
  - fire in IDLE gives fire_ack/fire_drop on the next cycle, and the slot is visible on rd_* from that same cycle.
  - fire during a sweep is answered the cycle after DONE.
- A sweep takes exactly N_TIROS cycles of MOVE plus 1 cycle of DONE. busy is high from the cycle after tick through DONE inclusive.
- hit is asserted in the cycle after slot idx is processed (registered), and hit_idx is valid with it.
- A reset_n low mid-sweep clears everything on the next edge, including pending requests. No done pulse is issued.
- Coordinates never wrap; the extra arithmetic bit detects underflow at 0 and overflow beyond COOR_W.

## Configuration

- TIRO_COOLDOWN_EN defined:
  - A spawn loads cooldown with COOLDOWN; each DONE decrements it.
  - fire while cooldown ≠ 0 gives fire_drop.
- TIRO_COOLDOWN_EN undefined: there is no cooldown counter, and fire is refused only when the table is full.

## Structure

- Package tiro_multi_pkg holds:
  - direction encoding constants (DIR_UP/RIGHT/DOWN/LEFT)
  - FSM state enum
  - slot struct {x, y, dir, valid}, parameterised via COOR_W
- Sub-module tiro_move: combinational; takes {x, y, dir} and the limits, and outputs next_x, next_y and out_of_field.
- Allocation (find-first-free priority encoder) and the FSM stay in the top level.

## Test plan

- Reset, then fire at (7,7), dir 01 → fire_ack next cycle; rd_addr 0 reads (7,7) valid; live_count 1.
- One tick after that spawn → busy for 17 cycles (16 MOVE + DONE); slot 0 = (8,7); done pulses once.
- Shot at (14,3) dir 01, tick → slot freed, no hit, live_count drops by 1.
- Shot at (4,5) dir 10, asteroid (4,6) with aste_valid=1, tick → hit with hit_idx = that slot; slot invalid.
- Fill all 16 slots (cooldown macro off), fire again → fire_drop; tick and fire together in IDLE → fire serviced after done.
- With TIRO_COOLDOWN_EN and COOLDOWN=3: spawn, then fire after 1 and 2 ticks → fire_drop; fire after 3 ticks → fire_ack.

Source files
------------

// File: rtl/tiro_multi_pkg.sv
// tiro_multi_pkg
//   Shared types for the tiro_multi shot manager.
//   - DIR_* : shot direction encoding as driven on nave_dir
//   - state_t : sequencing FSM states
//   - slot_t : one shot slot {x, y, dir, valid}. Coordinate width is
//     SLOT_COOR_W; the top-level COOR_W parameter must match it.
package tiro_multi_pkg;

    localparam int SLOT_COOR_W = 4;

    localparam logic [1:0] DIR_UP    = 2'b00;  // y - 1
    localparam logic [1:0] DIR_RIGHT = 2'b01;  // x + 1
    localparam logic [1:0] DIR_DOWN  = 2'b10;  // y + 1
    localparam logic [1:0] DIR_LEFT  = 2'b11;  // x - 1

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [SLOT_COOR_W-1:0] x;
        logic [SLOT_COOR_W-1:0] y;
        logic [1:0]             dir;
        logic                   valid;
    } slot_t;

endpackage

// File: rtl/tiro_multi_move.sv
// tiro_move
//   Combinational one-cell step of a single shot.
//   Ports:
//     x, y          in   current position
//     dir           in   direction (DIR_* encoding)
//     x_max, y_max  in   largest legal coordinate on each axis
//     next_x/next_y out  stepped position (low COOR_W bits)
//     out_of_field  out  step left the field (below 0 or above the limit)
module tiro_move
    import tiro_multi_pkg::*;
#(
    parameter int COOR_W = 4
) (
    input  logic [COOR_W-1:0] x,
    input  logic [COOR_W-1:0] y,
    input  logic [1:0]        dir,
    input  logic [COOR_W-1:0] x_max,
    input  logic [COOR_W-1:0] y_max,
    output logic [COOR_W-1:0] next_x,
    output logic [COOR_W-1:0] next_y,
    output logic              out_of_field
);

    localparam logic [COOR_W:0] ONE = (COOR_W+1)'(1);

    logic [COOR_W:0] wide_x;
    logic [COOR_W:0] wide_y;

    // One extra bit: stepping below 0 sets the MSB, so a single unsigned
    // compare against the limit catches both underflow and overflow.
    always_comb begin
        wide_x = {1'b0, x};
        wide_y = {1'b0, y};
        case (dir)
            DIR_UP:    wide_y = {1'b0, y} - ONE;
            DIR_RIGHT: wide_x = {1'b0, x} + ONE;
            DIR_DOWN:  wide_y = {1'b0, y} + ONE;
            default:   wide_x = {1'b0, x} - ONE;
        endcase
        next_x       = wide_x[COOR_W-1:0];
        next_y       = wide_y[COOR_W-1:0];
        out_of_field = (wide_x > {1'b0, x_max}) || (wide_y > {1'b0, y_max});
    end

endmodule

// File: rtl/tiro_multi.sv
// tiro_multi
//   Shot manager: owns N_TIROS shot slots, spawns shots from the ship,
//   advances every live shot one cell per tick and retires shots that leave
//   the field or hit the asteroid.
//   Optional feature macro: TIRO_COOLDOWN_EN (fire cooldown of COOLDOWN ticks).
//   Ports:
//     clock, reset_n              clock, synchronous active-low reset
//     tick                        start a movement sweep (pulse)
//     fire, nave_x/y, nave_dir    spawn request with ship position/direction
//     aste_valid, aste_x/y        asteroid under test (stable during a sweep)
//     rd_addr -> rd_valid/x/y     combinational slot read for the display
//     fire_ack / fire_drop        spawn accepted / refused (pulses)
//     hit, hit_idx                shot reached the asteroid, slot index
//     busy, done                  sweep in progress / sweep finished (pulse)
//     live_count                  number of valid slots
//   COOR_W must equal tiro_multi_pkg::SLOT_COOR_W (slot struct width).
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting; services fire or pending fire, tick starts a sweep
//   ST_MOVE | advances slot idx, one slot per cycle
//   ST_DONE | sweep finished; done pulse, cooldown decrement
module tiro_multi
    import tiro_multi_pkg::*;
#(
    parameter int N_TIROS  = 16,
    parameter int COOR_W   = SLOT_COOR_W,
    parameter int X_MAX    = 14,
    parameter int Y_MAX    = 14,
    parameter int COOLDOWN = 3
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         tick,
    input  logic                         fire,
    input  logic [COOR_W-1:0]            nave_x,
    input  logic [COOR_W-1:0]            nave_y,
    input  logic [1:0]                   nave_dir,
    input  logic                         aste_valid,
    input  logic [COOR_W-1:0]            aste_x,
    input  logic [COOR_W-1:0]            aste_y,
    input  logic [$clog2(N_TIROS)-1:0]   rd_addr,
    output logic                         rd_valid,
    output logic [COOR_W-1:0]            rd_x,
    output logic [COOR_W-1:0]            rd_y,
    output logic                         fire_ack,
    output logic                         fire_drop,
    output logic                         hit,
    output logic [$clog2(N_TIROS)-1:0]   hit_idx,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(N_TIROS+1)-1:0] live_count
);

    localparam int IDX_W = $clog2(N_TIROS);
    localparam int CNT_W = $clog2(N_TIROS+1);
    localparam logic [COOR_W-1:0] X_LIM    = COOR_W'(X_MAX);
    localparam logic [COOR_W-1:0] Y_LIM    = COOR_W'(Y_MAX);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_TIROS-1);

    state_t state;
    state_t state_nxt;

    slot_t              slots [N_TIROS];
    logic [IDX_W-1:0]   idx;

    logic               pend;
    logic [COOR_W-1:0]  pend_x;
    logic [COOR_W-1:0]  pend_y;
    logic [1:0]         pend_dir;

    logic               free_any;
    logic [IDX_W-1:0]   free_idx;

    logic               idle_serv;
    logic               queue_fire;
    logic               spawn;
    logic               cd_block;
    logic [COOR_W-1:0]  req_x;
    logic [COOR_W-1:0]  req_y;
    logic [1:0]         req_dir;

    logic [COOR_W-1:0]  mv_next_x;
    logic [COOR_W-1:0]  mv_next_y;
    logic               mv_oof;
    logic               mv_hit;

    tiro_move #(.COOR_W(COOR_W)) u_move (
        .x            (slots[idx].x),
        .y            (slots[idx].y),
        .dir          (slots[idx].dir),
        .x_max        (X_LIM),
        .y_max        (Y_LIM),
        .next_x       (mv_next_x),
        .next_y       (mv_next_y),
        .out_of_field (mv_oof)
    );

    assign mv_hit = aste_valid && (mv_next_x == aste_x) && (mv_next_y == aste_y);

    // Lowest-index free slot: scan downwards so the last hit wins.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = N_TIROS-1; i >= 0; i--) begin
            if (!slots[i].valid) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // A spawn attempt happens only in IDLE without a tick; a pending request
    // takes priority over a fresh fire, which is then refused.
    assign idle_serv  = (state == ST_IDLE) && !tick && (pend || fire);
    assign queue_fire = fire && ((state != ST_IDLE) || tick);
    assign spawn      = idle_serv && free_any && !cd_block;
    assign req_x      = pend ? pend_x   : nave_x;
    assign req_y      = pend ? pend_y   : nave_y;
    assign req_dir    = pend ? pend_dir : nave_dir;

`ifdef TIRO_COOLDOWN_EN
    localparam int CD_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN+1);

    logic [CD_W-1:0] cooldown;

    assign cd_block = (cooldown != '0);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cooldown <= '0;
        end else if (spawn) begin
            cooldown <= CD_W'(COOLDOWN);
        end else if ((state == ST_DONE) && (cooldown != '0)) begin
            cooldown <= cooldown - CD_W'(1);
        end
    end
`else
    assign cd_block = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tick) begin
                    state_nxt = ST_MOVE;
                end
            end
            ST_MOVE: begin
                busy = 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < N_TIROS; i++) begin
                slots[i] <= '0;
            end
            idx        <= '0;
            pend       <= 1'b0;
            pend_x     <= '0;
            pend_y     <= '0;
            pend_dir   <= '0;
            fire_ack   <= 1'b0;
            fire_drop  <= 1'b0;
            hit        <= 1'b0;
            hit_idx    <= '0;
            live_count <= '0;
        end else begin
            fire_ack  <= spawn;
            fire_drop <= (fire && pend) || (idle_serv && !spawn);
            hit       <= 1'b0;

            if (idle_serv) begin
                pend <= 1'b0;
            end else if (queue_fire && !pend) begin
                pend     <= 1'b1;
                pend_x   <= nave_x;
                pend_y   <= nave_y;
                pend_dir <= nave_dir;
            end

            if (spawn) begin
                slots[free_idx].x     <= req_x;
                slots[free_idx].y     <= req_y;
                slots[free_idx].dir   <= req_dir;
                slots[free_idx].valid <= 1'b1;
                live_count            <= live_count + CNT_W'(1);
            end

            if (state == ST_MOVE) begin
                idx <= idx + IDX_W'(1);
                if (slots[idx].valid) begin
                    if (mv_oof) begin
                        slots[idx].valid <= 1'b0;
                        live_count       <= live_count - CNT_W'(1);
                    end else if (mv_hit) begin
                        slots[idx].valid <= 1'b0;
                        live_count       <= live_count - CNT_W'(1);
                        hit              <= 1'b1;
                        hit_idx          <= idx;
                    end else begin
                        slots[idx].x <= mv_next_x;
                        slots[idx].y <= mv_next_y;
                    end
                end
            end else begin
                idx <= '0;
            end
        end
    end

    assign rd_valid = slots[rd_addr].valid;
    assign rd_x     = slots[rd_addr].x;
    assign rd_y     = slots[rd_addr].y;

endmodule

// File: tb/tb_tiro_multi.sv
// tb_tiro_multi
//   Directed bench for tiro_multi (N_TIROS=16, 4-bit coordinates, 0..14).
//   Inputs change 1 time unit after the rising edge and outputs are sampled
//   there as well. With TIRO_COOLDOWN_EN defined the cooldown sequence runs
//   instead of the default-build sequence.
module tb_tiro_multi;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       fire;
    logic [3:0] nave_x;
    logic [3:0] nave_y;
    logic [1:0] nave_dir;
    logic       aste_valid;
    logic [3:0] aste_x;
    logic [3:0] aste_y;
    logic [3:0] rd_addr;
    logic       rd_valid;
    logic [3:0] rd_x;
    logic [3:0] rd_y;
    logic       fire_ack;
    logic       fire_drop;
    logic       hit;
    logic [3:0] hit_idx;
    logic       busy;
    logic       done;
    logic [4:0] live_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    tiro_multi #(
        .N_TIROS  (16),
        .COOR_W   (4),
        .X_MAX    (14),
        .Y_MAX    (14),
        .COOLDOWN (3)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick       (tick),
        .fire       (fire),
        .nave_x     (nave_x),
        .nave_y     (nave_y),
        .nave_dir   (nave_dir),
        .aste_valid (aste_valid),
        .aste_x     (aste_x),
        .aste_y     (aste_y),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .fire_ack   (fire_ack),
        .fire_drop  (fire_drop),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .busy       (busy),
        .done       (done),
        .live_count (live_count)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fire_at(input int x, input int y, input int d);
        nave_x   = 4'(x);
        nave_y   = 4'(y);
        nave_dir = 2'(d);
        fire     = 1'b1;
        step();
        fire     = 1'b0;
    endtask

    task automatic check_slot(input string tag, input int a, input int v,
                              input int x, input int y);
        rd_addr = 4'(a);
        #1;
        check_val({tag, "_valid"}, int'(rd_valid), v);
        if (v == 1) begin
            check_val({tag, "_x"}, int'(rd_x), x);
            check_val({tag, "_y"}, int'(rd_y), y);
        end
    endtask

    // Tick, then follow the sweep until busy falls (bounded).
    task automatic sweep(output int busy_n, output int done_n,
                         output int hit_n, output int hit_at);
        busy_n = 0;
        done_n = 0;
        hit_n  = 0;
        hit_at = -1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        while (busy && busy_n < 40) begin
            busy_n++;
            if (done) done_n++;
            if (hit) begin
                hit_n++;
                hit_at = int'(hit_idx);
            end
            step();
        end
        if (hit) begin
            hit_n++;
            hit_at = int'(hit_idx);
        end
        check_val("sweep_bounded", int'(busy), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int bn, dn, hn, hi;
        int acks, ack_seen, drop_seen, wait_n;

        reset_n    = 1'b0;
        tick       = 1'b0;
        fire       = 1'b0;
        nave_x     = '0;
        nave_y     = '0;
        nave_dir   = '0;
        aste_valid = 1'b0;
        aste_x     = '0;
        aste_y     = '0;
        rd_addr    = '0;
        do_reset();

        check_val("rst_live", int'(live_count), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_ack", int'(fire_ack), 0);
        check_val("rst_hit", int'(hit), 0);
        check_slot("rst_slot0", 0, 0, 0, 0);

`ifdef TIRO_COOLDOWN_EN
        fire_at(7, 7, 1);
        check_val("cd_first_ack", int'(fire_ack), 1);
        fire_at(1, 1, 1);
        check_val("cd_0tick_drop", int'(fire_drop), 1);
        sweep(bn, dn, hn, hi);
        fire_at(1, 1, 1);
        check_val("cd_1tick_drop", int'(fire_drop), 1);
        check_val("cd_1tick_ack", int'(fire_ack), 0);
        sweep(bn, dn, hn, hi);
        fire_at(1, 1, 1);
        check_val("cd_2tick_drop", int'(fire_drop), 1);
        sweep(bn, dn, hn, hi);
        fire_at(1, 1, 1);
        check_val("cd_3tick_ack", int'(fire_ack), 1);
        check_val("cd_3tick_drop", int'(fire_drop), 0);
        check_val("cd_live", int'(live_count), 2);
        check_slot("cd_slot1", 1, 1, 1, 1);
`else
        // Spawn at (7,7) moving right.
        fire_at(7, 7, 1);
        check_val("spawn_ack", int'(fire_ack), 1);
        check_val("spawn_drop", int'(fire_drop), 0);
        check_val("spawn_live", int'(live_count), 1);
        check_slot("spawn_slot0", 0, 1, 7, 7);

        // First sweep: 16 MOVE + DONE, one done, slot 0 -> (8,7).
        sweep(bn, dn, hn, hi);
        check_val("sweep_busy_cycles", bn, 17);
        check_val("sweep_done_pulses", dn, 1);
        check_slot("sweep_slot0", 0, 1, 8, 7);

        // Right border: (14,3) right leaves the field silently.
        fire_at(14, 3, 1);
        check_val("border_ack", int'(fire_ack), 1);
        check_val("border_live_pre", int'(live_count), 2);
        sweep(bn, dn, hn, hi);
        check_val("border_hits", hn, 0);
        check_val("border_live", int'(live_count), 1);
        check_slot("border_slot1", 1, 0, 0, 0);
        check_slot("border_slot0", 0, 1, 9, 7);

        // Asteroid hit: (4,5) down onto asteroid at (4,6); lands in slot 1.
        fire_at(4, 5, 2);
        check_val("hit_spawn_ack", int'(fire_ack), 1);
        aste_valid = 1'b1;
        aste_x     = 4'd4;
        aste_y     = 4'd6;
        sweep(bn, dn, hn, hi);
        aste_valid = 1'b0;
        check_val("hit_count", hn, 1);
        check_val("hit_idx", hi, 1);
        check_val("hit_live", int'(live_count), 1);
        check_slot("hit_slot1", 1, 0, 0, 0);
        check_slot("hit_slot0", 0, 1, 10, 7);

        // Fill slots 1..15 with shots at (2,0) moving up (leave on next sweep).
        acks = 0;
        for (int i = 0; i < 15; i++) begin
            fire_at(2, 0, 0);
            if (fire_ack) acks++;
        end
        check_val("fill_acks", acks, 15);
        check_val("fill_live", int'(live_count), 16);
        fire_at(3, 3, 1);
        check_val("full_drop", int'(fire_drop), 1);
        check_val("full_ack", int'(fire_ack), 0);
        check_val("full_live", int'(live_count), 16);

        // Tick and fire together: fire is held pending and served after done.
        // A second fire mid-sweep is refused at once (pending is one deep).
        nave_x   = 4'd5;
        nave_y   = 4'd5;
        nave_dir = 2'd1;
        fire     = 1'b1;
        tick     = 1'b1;
        step();
        fire     = 1'b0;
        tick     = 1'b0;
        bn = 0;
        dn = 0;
        ack_seen  = 0;
        drop_seen = 0;
        while (busy && bn < 40) begin
            bn++;
            if (done) dn++;
            if (fire_ack) ack_seen++;
            if (bn == 3) begin
                nave_x   = 4'd9;
                nave_y   = 4'd9;
                nave_dir = 2'd0;
                fire     = 1'b1;
                step();
                fire     = 1'b0;
                drop_seen = int'(fire_drop);
                bn++;
            end else begin
                step();
            end
        end
        check_val("pend_sweep_bounded", int'(busy), 0);
        check_val("pend_sweep_done", dn, 1);
        check_val("pend_no_early_ack", ack_seen, 0);
        check_val("pend_second_drop", drop_seen, 1);
        wait_n = 0;
        while (!fire_ack && wait_n < 4) begin
            wait_n++;
            step();
        end
        check_val("pend_ack", int'(fire_ack), 1);
        check_val("pend_live", int'(live_count), 2);
        check_slot("pend_slot1", 1, 1, 5, 5);
        check_slot("pend_slot0", 0, 1, 11, 7);
        check_slot("pend_slot2", 2, 0, 0, 0);
`endif

        // Reset in the middle of a sweep clears everything, no done pulse.
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        check_val("midrst_busy_pre", int'(busy), 1);
        reset_n = 1'b0;
        step();
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_done", int'(done), 0);
        check_val("midrst_live", int'(live_count), 0);
        check_slot("midrst_slot0", 0, 0, 0, 0);
        reset_n = 1'b1;
        step();
        check_val("midrst_after_done", int'(done), 0);
        check_val("midrst_after_ack", int'(fire_ack), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
